alu_share_ctrl: RTL and testbench

//  Shares the single combinational `alu` instance between two requesters: port 0 = execute stage,

---
 rtl/alu_share_ctrl_pkg.sv | 22 ++
 rtl/alu.sv | 29 ++
 rtl/alu_share_ctrl_rr_arb2.sv | 8 +
 rtl/alu_share_ctrl.sv | 107 ++++++++++
 tb/tb_alu_share_ctrl.sv | 125 ++++++++++++
 5 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// alu_share_ctrl_pkg: shared widths, ALU command/flag encodings and controller states
package alu_share_ctrl_pkg;
  localparam int DATA_W = 8;
  localparam int CMD_W = 4;
  localparam int RES_W = 16;
  localparam int FLAG_W = 3;
  localparam int ALU_REQ_NUM = 2;
  localparam int FLAG_NEG = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO = 2;
  localparam logic [CMD_W-1:0] ALU_ADD = 4'd0;
  localparam logic [CMD_W-1:0] ALU_SUB = 4'd1;
  localparam logic [CMD_W-1:0] ALU_AND = 4'd2;
  localparam logic [CMD_W-1:0] ALU_OR = 4'd3;
  localparam logic [CMD_W-1:0] ALU_XOR = 4'd4;
  localparam logic [CMD_W-1:0] ALU_PASSTHROUGH = 4'd5;
  typedef enum logic [1:0] {
    ACTL_IDLE = 2'd0,
    ACTL_EXEC = 2'd1,
    ACTL_RESP = 2'd2
  } actl_state_e;
endpackage

// File: rtl/alu.sv
// alu: combinational 8-bit ALU with {Zero, Carry, Negative} flags, output forced to 0 in reset
module alu
  import alu_share_ctrl_pkg::*;
(
  input  logic              reset,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CMD_W-1:0]  cmnd,
  output logic [RES_W-1:0]  result,
  output logic [FLAG_W-1:0] flags
);
  logic [DATA_W:0] s;
  always_comb begin
    case (cmnd)
      ALU_ADD:         s = {1'b0, a} + {1'b0, b};
      ALU_SUB:         s = {1'b0, a} - {1'b0, b};
      ALU_AND:         s = {1'b0, a & b};
      ALU_OR:          s = {1'b0, a | b};
      ALU_XOR:         s = {1'b0, a ^ b};
      ALU_PASSTHROUGH: s = {1'b0, b};
      default:         s = '0;
    endcase
    result = reset ? RES_W'(s) : '0;
    flags = '0;
    flags[FLAG_ZERO] = (result[DATA_W-1:0] == '0);
    flags[FLAG_CARRY] = result[DATA_W];
    flags[FLAG_NEG] = result[DATA_W-1];
  end
endmodule

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on contention the port not granted last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between execute (port 0) and address unit (port 1)
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ALU_REQ_NUM-1:0] req_valid,
  output logic [ALU_REQ_NUM-1:0] req_ready,
  input  logic [DATA_W-1:0]      req0_a,
  input  logic [DATA_W-1:0]      req0_b,
  input  logic [CMD_W-1:0]       req0_cmnd,
  input  logic [DATA_W-1:0]      req1_a,
  input  logic [DATA_W-1:0]      req1_b,
  input  logic [CMD_W-1:0]       req1_cmnd,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [RES_W-1:0]       rsp_result,
  output logic [FLAG_W-1:0]      rsp_flags,
  output logic [FLAG_W-1:0]      arch_flags,
  output logic                   busy
);
  actl_state_e state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CMD_W-1:0] op_cmnd_q, op_cmnd_d;
  logic op_id_q, op_id_d, last_q, last_d, rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [RES_W-1:0] rsp_result_q, rsp_result_d, alu_result;
  logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d, arch_flags_q, arch_flags_d, alu_flags;
  logic [1:0] gnt;
  logic accept, sel;
  rr_arb2 u_arb (.req(req_valid), .last(last_q), .gnt(gnt));
  // ALU sees only the op regs, so request-port changes never reach the result path
  alu u_alu (.reset(reset), .a(op_a_q), .b(op_b_q), .cmnd(op_cmnd_q), .result(alu_result),
             .flags(alu_flags));
  assign req_ready = (reset && state_q == ACTL_IDLE) ? gnt : '0;
  assign accept = |(req_valid & req_ready);
  assign sel = req_ready[1];
  always_comb begin
    state_d = state_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    op_cmnd_d = op_cmnd_q;
    op_id_d = op_id_q;
    last_d = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d = rsp_flags_q;
    arch_flags_d = arch_flags_q;
    case (state_q)
      ACTL_IDLE: if (accept) begin
        op_a_d = sel ? req1_a : req0_a;
        op_b_d = sel ? req1_b : req0_b;
        op_cmnd_d = sel ? req1_cmnd : req0_cmnd;
        op_id_d = sel;
        last_d = sel;
        state_d = ACTL_EXEC;
      end
      ACTL_EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d = alu_flags;
        rsp_id_d = op_id_q;
        rsp_valid_d = 1'b1;
        arch_flags_d = op_id_q ? arch_flags_q : alu_flags;
        state_d = ACTL_RESP;
      end
      ACTL_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d = ACTL_IDLE;
      end
      default: state_d = ACTL_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACTL_IDLE;
      op_a_q <= '0;
      op_b_q <= '0;
      op_cmnd_q <= '0;
      op_id_q <= 1'b0;
      last_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q <= '0;
      arch_flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      op_cmnd_q <= op_cmnd_d;
      op_id_q <= op_id_d;
      last_q <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q <= rsp_flags_d;
      arch_flags_q <= arch_flags_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags = rsp_flags_q;
  assign arch_flags = arch_flags_q;
  assign busy = (state_q != ACTL_IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed vectors with hand-computed expectations for alu_share_ctrl
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] req_valid = 2'b00, req_ready;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0] req0_cmnd = '0, req1_cmnd = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_id, busy;
  logic [15:0] rsp_result;
  logic [2:0] rsp_flags, arch_flags;
  int n_chk = 0, n_fail = 0;
  alu_share_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cmnd(req0_cmnd),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cmnd(req1_cmnd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .arch_flags(arch_flags), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // caller leaves the bench in IDLE with req_valid set and rsp_ready=1
  task automatic run_op(input string tag, input logic [1:0] gnt, input logic id,
                        input logic [15:0] res, input logic [2:0] fl, input logic [2:0] arch,
                        input logic drop);
    chk({tag, " ready"}, 32'(req_ready), 32'(gnt));
    tick();
    if (drop) req_valid = 2'b00;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " early_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
    chk({tag, " rsp_result"}, 32'(rsp_result), 32'(res));
    chk({tag, " rsp_flags"}, 32'(rsp_flags), 32'(fl));
    chk({tag, " arch_flags"}, 32'(arch_flags), 32'(arch));
    tick();
    chk({tag, " done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask
  initial begin
    logic [15:0] c_res [4] = '{16'h0100, 16'h01ff, 16'h0000, 16'h01ff};
    logic [2:0] c_fl [4] = '{3'b110, 3'b011, 3'b100, 3'b011};
    logic [2:0] c_arch [4] = '{3'b110, 3'b110, 3'b100, 3'b100};
    req_valid = 2'b11;
    repeat (3) tick();
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst arch", 32'(arch_flags), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    req_valid = 2'b00;
    tick();
    reset = 1'b1;
    tick();
    req0_cmnd = ALU_PASSTHROUGH; req0_b = 8'h80; req_valid = 2'b01;
    #1;
    run_op("single0", 2'b01, 1'b0, 16'h0080, 3'b001, 3'b001, 1'b1);
    req1_cmnd = ALU_PASSTHROUGH; req1_b = 8'h00; req_valid = 2'b10;
    #1;
    run_op("port1", 2'b10, 1'b1, 16'h0000, 3'b100, 3'b001, 1'b1);
    req0_cmnd = ALU_ADD; req0_a = 8'hff; req0_b = 8'h01;
    req1_cmnd = ALU_SUB; req1_a = 8'h01; req1_b = 8'h02;
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("cont%0d", i), i[0] ? 2'b10 : 2'b01, i[0], c_res[i], c_fl[i],
             c_arch[i], 1'b0);
      if (i == 0) begin
        req0_cmnd = ALU_XOR; req0_a = 8'h55; req0_b = 8'h55;
      end
    end
    req_valid = 2'b00;
    req0_cmnd = ALU_ADD; req0_a = 8'h12; req0_b = 8'h34;
    rsp_ready = 1'b0; req_valid = 2'b01;
    tick();
    req_valid = 2'b11;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", 32'(rsp_valid), 32'd1);
      chk("bp result", 32'(rsp_result), 32'h46);
      chk("bp flags", 32'(rsp_flags), 32'd0);
      chk("bp ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    tick();
    chk("bp release busy", 32'(busy), 32'd0);
    chk("bp release valid", 32'(rsp_valid), 32'd0);
    req0_cmnd = ALU_PASSTHROUGH; req0_b = 8'h80; req_valid = 2'b01;
    #1;
    run_op("pre_abort", 2'b01, 1'b0, 16'h0080, 3'b001, 3'b001, 1'b1);
    req0_cmnd = ALU_ADD; req0_a = 8'h12; req0_b = 8'h34; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("abort in exec", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort arch", 32'(arch_flags), 32'd0);
    chk("abort ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post abort valid", 32'(rsp_valid), 32'd0);
    chk("post abort busy", 32'(busy), 32'd0);
    req_valid = 2'b11;
    #1;
    chk("post abort grant", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
